// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle execution unit for the RV32M multiply/divide instructions in
// the EX stage. The control unit holds `start` while an M-extension
// instruction sits in EX and stalls the pipeline until `ready` rises.
//
// Internally the block works on operand magnitudes:
//   - multiply: radix-2 shift-add, one multiplier bit per cycle
//   - divide:   restoring division, one quotient bit per cycle
// A single FIX cycle then applies the sign corrections and selects the
// result half. Divide-by-zero and signed overflow bypass the datapath and
// complete in one cycle.
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset
//   start    in   M-instruction present in EX (level)
//   funct3   in   operation select (MUL..REMU)
//   a, b     in   rs1 / rs2 operands, sampled only on launch
//   advance  in   EX moves to MEM this cycle; releases DONE
//   flush    in   EX instruction squashed; returns to IDLE from any state
//   ready    out  result valid (registered)
//   busy     out  operation in progress, CALC or FIX (registered)
//   result   out  registered result, held until the next load
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            advance,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic [BITS-1:0] result
);

    localparam int              CNT_W    = $clog2(BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS - 1);
    localparam logic [BITS-1:0] MIN_NEG  = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0] ALL_ONES = {BITS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*BITS-1:0]   acc_q, acc_d;
    logic [BITS-1:0]     opnd_q, opnd_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic [BITS-1:0]     result_q, result_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    // Launch-time decode: signedness, magnitudes and the divide special cases.
    logic                is_div;
    logic                a_signed;
    logic                b_signed;
    logic                a_neg;
    logic                b_neg;
    logic [BITS-1:0]     a_mag;
    logic [BITS-1:0]     b_mag;
    logic                div_by_zero;
    logic                div_ovf;
    logic                is_special;
    logic [BITS-1:0]     special_result;

    always_comb begin
        is_div      = funct3[2];
        a_signed    = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        b_signed    = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg       = a_signed && a[BITS-1];
        b_neg       = b_signed && b[BITS-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        div_by_zero = is_div && (b == '0);
        // Only the signed forms (funct3[0] = 0) can overflow.
        div_ovf     = is_div && !funct3[0] && (a == MIN_NEG) && (b == ALL_ONES);
        is_special  = div_by_zero || div_ovf;
        // funct3[1] separates remainder ops from quotient ops.
        if (div_by_zero) begin
            special_result = funct3[1] ? a : ALL_ONES;
        end else begin
            special_result = funct3[1] ? '0 : a;
        end
    end

    // One shift-add step: the multiplier sits in the low half of the
    // accumulator and is consumed LSB first while the partial product
    // grows into the high half; the carry is kept by the right shift.
    logic [BITS:0]       mul_addend;
    logic [BITS:0]       mul_sum;
    logic [2*BITS-1:0]   mul_next;

    always_comb begin
        mul_addend = acc_q[0] ? {1'b0, opnd_q} : '0;
        mul_sum    = {1'b0, acc_q[2*BITS-1:BITS]} + mul_addend;
        mul_next   = {mul_sum, acc_q[BITS-1:1]};
    end

    // One restoring-divide step on {rem, quot}. The shifted remainder needs
    // one extra bit because it can reach twice the divisor, and the
    // difference one more bit again to expose the borrow.
    logic [BITS:0]       rem_shift;
    logic [BITS+1:0]     div_diff;
    logic                div_borrow;
    logic [2*BITS-1:0]   div_next;

    always_comb begin
        rem_shift  = acc_q[2*BITS-1:BITS-1];
        div_diff   = {1'b0, rem_shift} - {2'b00, opnd_q};
        div_borrow = div_diff[BITS+1];
        if (div_borrow) begin
            div_next = {rem_shift[BITS-1:0], acc_q[BITS-2:0], 1'b0};
        end else begin
            div_next = {div_diff[BITS-1:0], acc_q[BITS-2:0], 1'b1};
        end
    end

    // Sign correction and result selection used in FIX. The sign flags are
    // only set for operands treated as signed, so a plain XOR covers the
    // product and quotient; the remainder follows the dividend.
    logic [2*BITS-1:0]   prod_fix;
    logic [BITS-1:0]     quot_fix;
    logic [BITS-1:0]     rem_fix;
    logic [BITS-1:0]     fix_result;

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[BITS-1:0] : acc_q[BITS-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*BITS-1:BITS] : acc_q[2*BITS-1:BITS];
        case (op_q)
            3'b000:                 fix_result = prod_fix[BITS-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*BITS-1:BITS];
            3'b100, 3'b101:         fix_result = quot_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic. flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = is_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (advance) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Datapath and output next values. Nothing is loaded while flush is
    // high, so a squashed instruction never disturbs result. ready/busy are
    // decoded from the next state so they are registered in step with it.
    always_comb begin
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        if (!flush) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d    = funct3;
                        neg_a_d = a_neg;
                        neg_b_d = b_neg;
                        cnt_d   = '0;
                        // Multiply: a is the multiplier, b the multiplicand.
                        // Divide: a is the dividend, b the divisor.
                        acc_d   = {{BITS{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                        if (is_special) begin
                            result_d = special_result;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                end
                S_FIX: begin
                    result_d = fix_result;
                end
                default: begin
                end
            endcase
        end
        ready_d = (state_d == S_DONE);
        busy_d  = (state_d == S_CALC) || (state_d == S_FIX);
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Self-checking bench for muldiv_sequencer (BITS = 32). Expected results come
// from a 64-bit reference model and are queued at launch, then popped and
// compared when ready rises. Cycle numbering: the cycle in which start is
// first presented is cycle 0; outputs are sampled 1 time unit after each
// rising edge.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int BITS    = 32;
    localparam int NORM_LAT = BITS + 2;
    localparam int MAX_WAIT = 60;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic            advance;
    logic            flush;
    logic            ready;
    logic            busy;
    logic [BITS-1:0] result;

    int n_checks = 0;
    int n_errors = 0;
    logic [BITS-1:0] exp_q[$];

    muldiv_sequencer #(.BITS(BITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .a       (a),
        .b       (b),
        .advance (advance),
        .flush   (flush),
        .ready   (ready),
        .busy    (busy),
        .result  (result)
    );

    always #5 clk = ~clk;

    // Reference model built on 64-bit host arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        logic [63:0] p;
        case (f)
            3'b000: begin p = sx * sy; return p[31:0]; end
            3'b001: begin p = sx * sy; return p[63:32]; end
            3'b010: begin p = sx * uy; return p[63:32]; end
            3'b011: begin p = ux * uy; return p[63:32]; end
            3'b100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                p = sx / sy; return p[31:0];
            end
            3'b101: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'b110: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && y == 0) return 1;
        if (f[2] && !f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return NORM_LAT;
    endfunction

    // Waits (bounded) for ready after a launch in the current cycle, checking
    // the busy profile each cycle. Operands are scrambled after launch to
    // show they are only sampled once.
    task automatic wait_ready(input int exp_lat, input string name, output int cyc);
        int busy_bad;
        logic exp_busy;
        cyc = 0;
        busy_bad = 0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                a = $urandom;
                b = $urandom;
                funct3 = 3'($urandom);
            end
            exp_busy = (exp_lat != 1) && (cyc <= BITS + 1);
            if (busy !== exp_busy) busy_bad++;
            if (ready === 1'b1) break;
        end
        n_checks++;
        if (busy_bad !== 0) begin
            n_errors++;
            $display("[TB] FAIL %s busy_profile: got %0d wrong cycles, expected 0", name, busy_bad);
        end
        n_checks++;
        if (cyc !== exp_lat) begin
            n_errors++;
            $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_lat);
        end
    endtask

    task automatic check_result(input string name);
        logic [BITS-1:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected one entry", name);
            return;
        end
        exp = exp_q.pop_front();
        if (result !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s result: got %h, expected %h", name, result, exp);
        end
    endtask

    // Full transaction: launch in the current cycle, wait, compare, advance.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv, input string name);
        int cyc;
        int lat;
        lat = model_latency(f3, av, bv);
        exp_q.push_back(model(f3, av, bv));
        start  = 1'b1;
        funct3 = f3;
        a      = av;
        b      = bv;
        wait_ready(lat, name, cyc);
        check_result(name);
        advance = 1'b1;
        @(posedge clk); #1;
        advance = 1'b0;
        start   = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL %s after_advance: got ready=%b busy=%b, expected 0 0", name, ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; funct3 = '0; a = '0; b = '0; advance = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_state: got ready=%b busy=%b result=%h, expected 0 0 0", ready, busy, result);
        end
    endtask

    task automatic test_mul();
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, "mulh_min_min");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
    endtask

    task automatic test_div();
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(3'b101, 32'hFFFF_FFF9, 32'd2, "divu_big_2");
        run_op(3'b111, 32'hFFFF_FFF9, 32'd2, "remu_big_2");
    endtask

    task automatic test_special();
        run_op(3'b101, 32'd5, 32'd0, "divu_by_zero");
        run_op(3'b110, 32'd5, 32'd0, "rem_by_zero");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
    endtask

    task automatic test_flush();
        int ready_seen;
        // flush together with start in IDLE must not launch
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL flush_beats_start: got busy=%b ready=%b, expected 0 0", busy, ready);
        end
        // DIV squashed at cycle 10
        ready_seen = 0;
        start = 1'b1; funct3 = 3'b100; a = 32'd100; b = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) ready_seen++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL flush_cycle11: got busy=%b ready=%b, expected 0 0", busy, ready);
        end
        @(posedge clk); #1;
        if (ready === 1'b1) ready_seen++;
        n_checks++;
        if (ready_seen !== 0) begin
            n_errors++;
            $display("[TB] FAIL flush_no_ready: got %0d ready cycles, expected 0", ready_seen);
        end
        // cycle 12: fresh MUL, ready expected 34 cycles later (cycle 46)
        run_op(3'b000, 32'd3, 32'd4, "mul_after_flush");
    endtask

    task automatic test_hold();
        int cyc;
        int unstable;
        logic [BITS-1:0] held;
        exp_q.push_back(model(3'b101, 32'd1000, 32'd33));
        start = 1'b1; funct3 = 3'b101; a = 32'd1000; b = 32'd33;
        wait_ready(NORM_LAT, "hold_divu", cyc);
        held = result;
        check_result("hold_divu");
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ready !== 1'b1 || result !== held) unstable++;
        end
        n_checks++;
        if (unstable !== 0) begin
            n_errors++;
            $display("[TB] FAIL hold_stable: got %0d unstable cycles, expected 0", unstable);
        end
        // flush from DONE drops ready but leaves result alone
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || result !== 32'd30) begin
            n_errors++;
            $display("[TB] FAIL flush_done: got ready=%b result=%h, expected 0 0000001e", ready, result);
        end
    endtask

    task automatic test_reset_mid();
        int activity;
        start = 1'b1; funct3 = 3'b000; a = 32'd11; b = 32'd13;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || result !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_mid_calc: got ready=%b busy=%b result=%h, expected 0 0 0", ready, busy, result);
        end
        activity = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1 || busy === 1'b1) activity++;
        end
        n_checks++;
        if (activity !== 0) begin
            n_errors++;
            $display("[TB] FAIL reset_abandons: got %0d active cycles, expected 0", activity);
        end
        run_op(3'b000, 32'd6, 32'd7, "mul_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] picks[4];
        picks[0] = 32'h0;
        picks[1] = 32'h8000_0000;
        picks[2] = 32'hFFFF_FFFF;
        picks[3] = 32'h1;
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom);
            x  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : $urandom;
            y  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : $urandom;
            run_op(f3, x, y, $sformatf("rand%0d_f%0d", i, f3));
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
